inert_intf: RTL and testbench

INERT_INTF -- requirements
Module: inert_intf

---
 rtl/inert_pkg.sv | 28 ++
 rtl/inert_intf_if.sv | 11 +
 rtl/inert_intf_spi.sv | 73 +++++++
 rtl/inert_intf.sv | 143 ++++++++++++++
 tb/tb_inert_intf.sv | 264 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/inert_pkg.sv
// Shared types and constants for the inertial sensor front end.
package inert_pkg;

    typedef enum logic [2:0] {
        PWR_WAIT,
        INIT1,
        INIT2,
        INIT3,
        INIT4,
        WAIT_INT,
        READ,
        PUBLISH
    } state_t;

    localparam logic [15:0] INIT_CMD1 = 16'h0D02;
    localparam logic [15:0] INIT_CMD2 = 16'h1062;
    localparam logic [15:0] INIT_CMD3 = 16'h1162;
    localparam logic [15:0] INIT_CMD4 = 16'h1460;

    localparam logic [7:0] RD_BASE = 8'hA2;
    localparam logic [3:0] RD_LAST = 4'd9;

    // Read frame for the idx-th data register: {1, addr[6:0]} followed by a dummy byte.
    function automatic logic [15:0] rd_cmd(input logic [3:0] idx);
        return {RD_BASE + {4'b0000, idx}, 8'h00};
    endfunction

endpackage

// File: rtl/inert_intf_if.sv
// SPI-plus-interrupt bus between the inertial front end and the sensor.
interface inert_intf_if;
    logic SS_n;
    logic SCLK;
    logic MOSI;
    logic MISO;
    logic INT;

    modport master (output SS_n, SCLK, MOSI, input MISO, INT);
    modport slave  (input SS_n, SCLK, MOSI, output MISO, INT);
endinterface

// File: rtl/inert_intf_spi.sv
// 16-bit SPI master, mode 3, SCLK = clk/32; one frame per wrt pulse, done pulse at the end.
module SPI_mnrch (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        wrt,
    input  logic [15:0] cmd,
    output logic        done,
    output logic [15:0] rd_data,
    output logic        SS_n,
    output logic        SCLK,
    output logic        MOSI,
    input  logic        MISO
);

    logic        r_busy;
    logic [4:0]  r_div;
    logic [4:0]  r_nfall;
    logic [15:0] r_shft;
    logic        r_miso;
    logic        r_ss_n;
    logic        r_done;

    // SCLK is r_div[4]: idle parks at all-ones, a frame starts at 16 to give a half-period front porch.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_busy  <= 1'b0;
            r_div   <= '1;
            r_nfall <= '0;
            r_shft  <= '0;
            r_miso  <= 1'b0;
            r_ss_n  <= 1'b1;
            r_done  <= 1'b0;
        end else begin
            r_done <= 1'b0;
            if (!r_busy) begin
                if (wrt) begin
                    r_busy  <= 1'b1;
                    r_ss_n  <= 1'b0;
                    r_div   <= 5'd16;
                    r_nfall <= '0;
                    r_shft  <= cmd;
                end
            end else begin
                if (r_div == 5'd15) begin
                    r_miso <= MISO;
                end
                if (r_div == '1) begin
                    // The first falling edge only ends the porch; the next 16 each shift one bit.
                    if (r_nfall != '0) begin
                        r_shft <= {r_shft[14:0], r_miso};
                    end
                    if (r_nfall == 5'd16) begin
                        r_busy <= 1'b0;
                        r_ss_n <= 1'b1;
                        r_done <= 1'b1;
                    end else begin
                        r_div   <= r_div + 5'd1;
                        r_nfall <= r_nfall + 5'd1;
                    end
                end else begin
                    r_div <= r_div + 5'd1;
                end
            end
        end
    end

    assign done    = r_done;
    assign rd_data = r_shft;
    assign SS_n    = r_ss_n;
    assign SCLK    = r_div[4];
    assign MOSI    = r_shft[15];

endmodule

// File: rtl/inert_intf.sv
// Inertial sensor front end: power-up wait, init writes, then interrupt-driven
// burst reads of the gyro and accelerometer registers over one SPI master.
module inert_intf
    import inert_pkg::*;
#(
    parameter int TMR_WIDTH = 16
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               INT,
    input  logic               MISO,
    output logic               SS_n,
    output logic               SCLK,
    output logic               MOSI,
    output logic               vld,
    output logic signed [15:0] ptch_rt,
    output logic signed [15:0] roll_rt,
    output logic signed [15:0] yaw_rt,
    output logic signed [15:0] ax,
    output logic signed [15:0] ay
);

    state_t               r_state;
    logic [TMR_WIDTH-1:0] r_tmr;
    logic                 r_int_ff1;
    logic                 r_int_sync;
    logic                 r_wrt;
    logic [15:0]          r_cmd;
    logic [3:0]           r_idx;
    logic [7:0]           r_hold [0:9];
    logic                 r_vld;
    logic [15:0]          r_ptch, r_roll, r_yaw, r_ax, r_ay;
    logic                 w_done;
    logic [15:0]          w_rd_data;

    SPI_mnrch u_spi (
        .clk     (clk),
        .rst_n   (rst_n),
        .wrt     (r_wrt),
        .cmd     (r_cmd),
        .done    (w_done),
        .rd_data (w_rd_data),
        .SS_n    (SS_n),
        .SCLK    (SCLK),
        .MOSI    (MOSI),
        .MISO    (MISO)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_int_ff1  <= 1'b0;
            r_int_sync <= 1'b0;
        end else begin
            r_int_ff1  <= INT;
            r_int_sync <= r_int_ff1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= PWR_WAIT;
            r_tmr   <= '0;
            r_wrt   <= 1'b0;
            r_cmd   <= '0;
            r_idx   <= '0;
            r_vld   <= 1'b0;
            r_ptch  <= '0;
            r_roll  <= '0;
            r_yaw   <= '0;
            r_ax    <= '0;
            r_ay    <= '0;
            for (int unsigned i = 0; i < 10; i++) begin
                r_hold[i] <= '0;
            end
        end else begin
            r_wrt <= 1'b0;
            r_vld <= 1'b0;
            case (r_state)
                PWR_WAIT: begin
                    if (r_tmr == '1) begin
                        r_state <= INIT1;
                        r_wrt   <= 1'b1;
                        r_cmd   <= INIT_CMD1;
                    end else begin
                        r_tmr <= r_tmr + TMR_WIDTH'(1);
                    end
                end
                INIT1: if (w_done) begin
                    r_state <= INIT2;
                    r_wrt   <= 1'b1;
                    r_cmd   <= INIT_CMD2;
                end
                INIT2: if (w_done) begin
                    r_state <= INIT3;
                    r_wrt   <= 1'b1;
                    r_cmd   <= INIT_CMD3;
                end
                INIT3: if (w_done) begin
                    r_state <= INIT4;
                    r_wrt   <= 1'b1;
                    r_cmd   <= INIT_CMD4;
                end
                INIT4: if (w_done) begin
                    r_state <= WAIT_INT;
                end
                WAIT_INT: if (r_int_sync) begin
                    r_state <= READ;
                    r_idx   <= '0;
                    r_wrt   <= 1'b1;
                    r_cmd   <= rd_cmd(4'd0);
                end
                READ: if (w_done) begin
                    r_hold[r_idx] <= w_rd_data[7:0];
                    if (r_idx == RD_LAST) begin
                        // Publish on the last done so vld and the outputs appear in the PUBLISH cycle;
                        // the final high byte comes straight from the SPI data.
                        r_state <= PUBLISH;
                        r_vld   <= 1'b1;
                        r_ptch  <= {r_hold[1], r_hold[0]};
                        r_roll  <= {r_hold[3], r_hold[2]};
                        r_yaw   <= {r_hold[5], r_hold[4]};
                        r_ax    <= {r_hold[7], r_hold[6]};
                        r_ay    <= {w_rd_data[7:0], r_hold[8]};
                    end else begin
                        r_idx <= r_idx + 4'd1;
                        r_wrt <= 1'b1;
                        r_cmd <= rd_cmd(r_idx + 4'd1);
                    end
                end
                PUBLISH: r_state <= WAIT_INT;
                default: r_state <= PWR_WAIT;
            endcase
        end
    end

    assign vld     = r_vld;
    assign ptch_rt = r_ptch;
    assign roll_rt = r_roll;
    assign yaw_rt  = r_yaw;
    assign ax      = r_ax;
    assign ay      = r_ay;

endmodule

// File: tb/tb_inert_intf.sv
// Directed bench for inert_intf: SPI sensor model, vector table of register contents,
// plus power-up, INT-held and mid-frame reset sequences.
module tb_inert_intf;

    typedef struct packed {
        logic [0:9][7:0]  b;
        logic [0:4][15:0] e;
        logic             tog;
    } vec_t;

    logic clk = 1'b0;
    logic rst_n;
    logic vld;
    logic signed [15:0] ptch_rt, roll_rt, yaw_rt, ax, ay;

    inert_intf_if sif ();

    inert_intf #(.TMR_WIDTH(4)) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .INT     (sif.INT),
        .MISO    (sif.MISO),
        .SS_n    (sif.SS_n),
        .SCLK    (sif.SCLK),
        .MOSI    (sif.MOSI),
        .vld     (vld),
        .ptch_rt (ptch_rt),
        .roll_rt (roll_rt),
        .yaw_rt  (yaw_rt),
        .ax      (ax),
        .ay      (ay)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_pass   = 0;

    logic [7:0]  mem [0:9];
    logic [15:0] frames [$];
    logic [15:0] frm        = '0;
    logic [7:0]  rdbyte     = '0;
    int          cnt        = 16;
    int          bad_frames = 0;
    int          vld_cnt    = 0;
    logic        prev_ss    = 1'b1;
    logic        prev_sclk  = 1'b1;

    // Sensor model: samples MOSI after each SCLK rise, answers reads of 0xA2..0xAB in the data byte.
    always @(negedge clk) begin
        if (vld) vld_cnt++;
        if (!sif.SS_n && prev_ss) begin
            cnt = 0;
            frm = '0;
            rdbyte = '0;
        end
        if (!sif.SS_n && sif.SCLK && !prev_sclk) begin
            frm = {frm[14:0], sif.MOSI};
            cnt++;
            if (cnt == 8) begin
                if (frm[7:0] >= 8'hA2 && frm[7:0] <= 8'hAB) rdbyte = mem[int'(frm[7:0]) - 'hA2];
                else rdbyte = 8'h00;
            end
        end
        if (sif.SS_n && !prev_ss) begin
            if (cnt == 16) frames.push_back(frm);
            else if (rst_n) bad_frames++;
        end
        sif.MISO = (cnt >= 8 && cnt < 16) ? rdbyte[15 - cnt] : 1'b0;
        prev_ss   = sif.SS_n;
        prev_sclk = sif.SCLK;
    end

    task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", name, act, exp);
    endtask

    task automatic chk_outs(input string tag, input logic [0:4][15:0] e);
        chk({tag, "_ptch"}, ptch_rt, e[0]);
        chk({tag, "_roll"}, roll_rt, e[1]);
        chk({tag, "_yaw"},  yaw_rt,  e[2]);
        chk({tag, "_ax"},   ax,      e[3]);
        chk({tag, "_ay"},   ay,      e[4]);
    endtask

    function automatic logic outs_eq(input logic [0:4][15:0] e);
        return ptch_rt === e[0] && roll_rt === e[1] && yaw_rt === e[2] && ax === e[3] && ay === e[4];
    endfunction

    task automatic load_mem(input logic [0:9][7:0] b);
        for (int k = 0; k < 10; k++) mem[k] = b[k];
    endtask

    task automatic chk_init(input string tag, input int base);
        chk({tag, "_init1"}, frames[base],     16'h0D02);
        chk({tag, "_init2"}, frames[base + 1], 16'h1062);
        chk({tag, "_init3"}, frames[base + 2], 16'h1162);
        chk({tag, "_init4"}, frames[base + 3], 16'h1460);
    endtask

    vec_t vecs [4];

    initial begin
        int   base;
        int   vb;
        logic got;
        logic ss_ok;
        logic ok;
        int   t [3];
        int   np;
        logic [7:0] a;

        vecs[0].b = {8'h34, 8'h12, 8'hCD, 8'hAB, 8'h00, 8'h80, 8'hFF, 8'h7F, 8'h01, 8'h00};
        vecs[0].e = {16'h1234, 16'hABCD, 16'h8000, 16'h7FFF, 16'h0001};
        vecs[0].tog = 1'b0;
        vecs[1].b = {8'h01, 8'h00, 8'h02, 8'h00, 8'h03, 8'h00, 8'h04, 8'h00, 8'h05, 8'h00};
        vecs[1].e = {16'h0001, 16'h0002, 16'h0003, 16'h0004, 16'h0005};
        vecs[1].tog = 1'b1;
        vecs[2].b = {8'hFF, 8'hFF, 8'h00, 8'h00, 8'h55, 8'hAA, 8'hAA, 8'h55, 8'h80, 8'h7F};
        vecs[2].e = {16'hFFFF, 16'h0000, 16'hAA55, 16'h55AA, 16'h7F80};
        vecs[2].tog = 1'b1;
        vecs[3].b = {8'h78, 8'h56, 8'hBC, 8'h9A, 8'hF0, 8'hDE, 8'h32, 8'h10, 8'h76, 8'h54};
        vecs[3].e = {16'h5678, 16'h9ABC, 16'hDEF0, 16'h1032, 16'h5476};
        vecs[3].tog = 1'b0;

        // Reset state and power-up sequence
        sif.INT = 1'b0;
        rst_n = 1'b0;
        load_mem(vecs[0].b);
        repeat (3) @(negedge clk);
        #1;
        chk("rst_SS_n", {15'd0, sif.SS_n}, 16'd1);
        chk("rst_SCLK", {15'd0, sif.SCLK}, 16'd1);
        chk("rst_MOSI", {15'd0, sif.MOSI}, 16'd0);
        chk("rst_vld",  {15'd0, vld},      16'd0);
        chk_outs("rst", '0);
        @(negedge clk);
        base = frames.size();
        rst_n = 1'b1;
        ss_ok = 1'b1;
        repeat (15) begin
            @(negedge clk);
            if (!sif.SS_n) ss_ok = 1'b0;
        end
        chk("pwr_wait_SS_n_high", {15'd0, ss_ok}, 16'd1);
        for (int c = 0; c < 3000 && frames.size() < base + 4; c++) @(negedge clk);
        chk("init_frame_count", 16'(frames.size() - base), 16'd4);
        if (frames.size() >= base + 4) chk_init("pwr", base);
        repeat (300) @(negedge clk);
        chk("idle_no_extra_frames", 16'(frames.size() - base), 16'd4);
        chk("idle_no_vld", 16'(vld_cnt), 16'd0);

        // Table of sensor register contents, one INT-triggered burst each
        for (int v = 0; v < 4; v++) begin
            load_mem(vecs[v].b);
            base = frames.size();
            vb = vld_cnt;
            got = 1'b0;
            for (int c = 0; c < 7000 && !got; c++) begin
                if (c < 3) sif.INT = 1'b1;
                else if (vecs[v].tog && c >= 1000 && c < 3000) sif.INT = c[5];
                else sif.INT = 1'b0;
                @(negedge clk);
                if (vld) got = 1'b1;
            end
            sif.INT = 1'b0;
            chk($sformatf("v%0d_vld_seen", v), {15'd0, got}, 16'd1);
            chk_outs($sformatf("v%0d", v), vecs[v].e);
            repeat (600) @(negedge clk);
            chk($sformatf("v%0d_frames", v), 16'(frames.size() - base), 16'd10);
            chk($sformatf("v%0d_vld_count", v), 16'(vld_cnt - vb), 16'd1);
            ok = 1'b1;
            if (frames.size() >= base + 10) begin
                for (int k = 0; k < 10; k++) begin
                    a = 8'hA2 + 8'(k);
                    if (frames[base + k] !== {a, 8'h00}) ok = 1'b0;
                end
            end else ok = 1'b0;
            chk($sformatf("v%0d_read_addrs", v), {15'd0, ok}, 16'd1);
        end

        // INT held high: back-to-back bursts, fixed vld period, outputs frozen between pulses
        load_mem(vecs[0].b);
        base = frames.size();
        np = 0;
        ss_ok = 1'b1;
        sif.INT = 1'b1;
        for (int c = 0; c < 20000 && np < 3; c++) begin
            @(negedge clk);
            if (vld) begin
                t[np] = c;
                if (np == 0) begin
                    chk_outs("hold_p1", vecs[0].e);
                    load_mem(vecs[1].b);
                end else if (np == 1) begin
                    chk_outs("hold_p2", vecs[1].e);
                end else begin
                    chk("hold_frames_at_p3", 16'(frames.size() - base), 16'd30);
                    sif.INT = 1'b0;
                end
                np++;
            end else if (np == 1) begin
                if (!outs_eq(vecs[0].e)) ss_ok = 1'b0;
            end else if (np == 2) begin
                if (!outs_eq(vecs[1].e)) ss_ok = 1'b0;
            end
        end
        sif.INT = 1'b0;
        chk("hold_pulse_count", 16'(np), 16'd3);
        chk("hold_outputs_stable", {15'd0, ss_ok}, 16'd1);
        if (np == 3) begin
            chk("hold_period_1", 16'(t[1] - t[0]), 16'd5302);
            chk("hold_period_2", 16'(t[2] - t[1]), 16'd5302);
        end

        // Reset in the middle of a read frame, after seven bits
        got = 1'b0;
        for (int c = 0; c < 3000 && !got; c++) begin
            @(negedge clk);
            if (!sif.SS_n && cnt == 7) got = 1'b1;
        end
        chk("midframe_reached", {15'd0, got}, 16'd1);
        rst_n = 1'b0;
        #1;
        chk("midrst_SS_n", {15'd0, sif.SS_n}, 16'd1);
        chk("midrst_SCLK", {15'd0, sif.SCLK}, 16'd1);
        chk("midrst_vld",  {15'd0, vld},      16'd0);
        chk_outs("midrst", '0);
        repeat (3) @(negedge clk);
        sif.INT = 1'b1;
        base = frames.size();
        vb = vld_cnt;
        rst_n = 1'b1;
        ss_ok = 1'b1;
        repeat (15) begin
            @(negedge clk);
            if (!sif.SS_n) ss_ok = 1'b0;
        end
        chk("re_pwr_wait_SS_n_high", {15'd0, ss_ok}, 16'd1);
        for (int c = 0; c < 4000 && frames.size() < base + 5; c++) @(negedge clk);
        sif.INT = 1'b0;
        chk("re_frame_count", 16'(frames.size() - base), 16'd5);
        if (frames.size() >= base + 5) begin
            chk_init("re", base);
            chk("re_first_read", frames[base + 4], 16'hA200);
        end
        got = 1'b0;
        for (int c = 0; c < 7000 && !got; c++) begin
            @(negedge clk);
            if (vld) got = 1'b1;
        end
        chk("re_vld_seen", {15'd0, got}, 16'd1);
        chk_outs("re", vecs[1].e);
        repeat (20) @(negedge clk);
        chk("re_vld_count", 16'(vld_cnt - vb), 16'd1);
        chk("bad_frames", 16'(bad_frames), 16'd0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
